// File: rtl/quad_edge_gen.sv
// Quadrature edge generator: one Gray-code a/b step per accepted request, minimum edge
// spacing of HOLD_CYCLES, wrapping position count. Optional index pulse: QUAD_INDEX_EN.
module quad_edge_gen #(
  parameter int HOLD_CYCLES = 4,
  parameter int POS_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             step_valid,
  input  logic             step_dir,
  output logic             step_ready,
  output logic             a,
  output logic             b,
  output logic             z,
  output logic [POS_W-1:0] pos
);

  // Counter only needs to reach HOLD_CYCLES-2, so HOLD_CYCLES-1 always fits.
  localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((HOLD_CYCLES > 1) ? HOLD_CYCLES - 2 : 0);

  typedef enum logic {S_IDLE, S_HOLD} state_t;

  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               a_q, b_q, ready_q;
  logic [POS_W-1:0]   pos_q;
  logic               a_d, b_d;
  logic [POS_W-1:0]   pos_d;
  logic               accept;

  assign accept = step_valid & ready_q;

  // Forward walks 00->10->11->01 (a leads b); reverse walks the same ring backwards.
  always_comb begin
    a_d   = step_dir ? ~b_q : b_q;
    b_d   = step_dir ? a_q  : ~a_q;
    pos_d = step_dir ? pos_q + POS_W'(1) : pos_q - POS_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
      pos_q   <= '0;
      ready_q <= 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            a_q   <= a_d;
            b_q   <= b_d;
            pos_q <= pos_d;
            if (HOLD_CYCLES > 1) begin
              state_q <= S_HOLD;
              ready_q <= 1'b0;
              cnt_q   <= CNT_LOAD;
            end
          end
        end
        S_HOLD: begin
          if (cnt_q == '0) begin
            state_q <= S_IDLE;
            ready_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        default: begin
          state_q <= S_IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

`ifdef QUAD_INDEX_EN
  logic z_q;

  // Pulses alongside the pos update that lands on zero, from either direction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      z_q <= 1'b0;
    end else begin
      z_q <= accept && (pos_d == '0);
    end
  end

  assign z = z_q;
`else
  assign z = 1'b0;
`endif

  assign step_ready = ready_q;
  assign a          = a_q;
  assign b          = b_q;
  assign pos        = pos_q;

endmodule
